// File: rtl/bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : bus_mem_responder
// Purpose  : Memory-side responder on the CPU's shared addr/data/wr_en bus.
//            Clears its array after reset, then accepts loader preloads. It
//            then serves CPU reads (combinational drive of data_bus) and
//            commits CPU writes, gated on the CPU boot-done flag.
// Revision : 1.0 - initial release
// ============================================================================
module bus_mem_responder #(
  parameter int WORD_SIZE      = 8,
  parameter int ADDR_SIZE      = 8,
  parameter int ADDR_STEP_LOG2 = 1,
  parameter int DEPTH          = 2**(ADDR_SIZE-ADDR_STEP_LOG2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE-1:0] addr_bus,
  inout  wire  [WORD_SIZE-1:0] data_bus,
  input  logic                 wr_en,
  input  logic                 cpu_boot_done,
  input  logic                 ld_valid,
  input  logic [ADDR_SIZE-1:0] ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  output logic                 ld_ready,
  output logic                 mem_ready,
  output logic [15:0]          wr_count,
  output logic                 misalign
);

  localparam int                   IDX_W    = ADDR_SIZE - ADDR_STEP_LOG2;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] LOW_MASK = ADDR_SIZE'((1 << ADDR_STEP_LOG2) - 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_LOAD  = 2'd1,
    S_SERVE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     clr_idx_q, clr_idx_d;
  logic [15:0]          wr_count_q;
  logic                 misalign_q;
  logic [WORD_SIZE-1:0] mem_q [DEPTH];

  logic                 cpu_active;
  logic [IDX_W-1:0]     cpu_idx;
  logic [IDX_W-1:0]     ld_idx;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 mem_we;
  logic [IDX_W-1:0]     mem_widx;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic                 misalign_set;
  logic                 cpu_wr_commit;

  // CPU traffic only counts while serving and the CPU reports boot done.
  assign cpu_active = (state_q == S_SERVE) && cpu_boot_done;
  assign cpu_idx    = IDX_W'(addr_bus >> ADDR_STEP_LOG2);
  assign ld_idx     = IDX_W'(ld_addr >> ADDR_STEP_LOG2);
  assign rd_data    = mem_q[cpu_idx];

  // Drive the shared bus only for a live CPU read; released otherwise.
  assign data_bus = (cpu_active && !wr_en) ? rd_data : {WORD_SIZE{1'bz}};

  assign cpu_wr_commit = cpu_active && wr_en;
  assign misalign_set  = (cpu_active && |(addr_bus & LOW_MASK)) ||
                         ((state_q == S_LOAD) && ld_valid && |(ld_addr & LOW_MASK));

  assign ld_ready  = (state_q == S_LOAD);
  assign mem_ready = (state_q == S_SERVE);
  assign wr_count  = wr_count_q;
  assign misalign  = misalign_q;

  // Next-state logic: clear sweep, preload window, serve with CPU fallback.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      S_INIT: begin
        if (clr_idx_q == LAST_IDX) begin
          clr_idx_d = '0;
          state_d   = S_LOAD;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      S_LOAD:  if (cpu_boot_done)  state_d = S_SERVE;
      S_SERVE: if (!cpu_boot_done) state_d = S_LOAD;
      default: state_d = S_INIT;
    endcase
  end

  // Select the single memory write port source for this cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = '0;
    case (state_q)
      S_INIT: begin
        mem_we   = 1'b1;
        mem_widx = clr_idx_q;
      end
      S_LOAD: begin
        mem_we    = ld_valid;
        mem_widx  = ld_idx;
        mem_wdata = ld_data;
      end
      S_SERVE: begin
        mem_we    = cpu_wr_commit;
        mem_widx  = cpu_idx;
        mem_wdata = data_bus;
      end
      default: mem_we = 1'b0;
    endcase
  end

  // Control registers: state, clear index, write counter, sticky misalign.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      clr_idx_q  <= '0;
      wr_count_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      if (cpu_wr_commit && (wr_count_q != 16'hFFFF)) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
      if (misalign_set) begin
        misalign_q <= 1'b1;
      end
    end
  end

  // Storage array; a reset edge writes nothing, the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

endmodule
`default_nettype wire

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-side responder for the CPU's shared address/data/write-enable bus.
- Holds program and operand words, returns read data on the shared inout data bus, and commits CPU write-backs.
- Accepts a testbench/loader preload stream while the CPU runs its boot sweep.
- Clears its array after reset and gates all CPU traffic on the CPU's boot-done flag.

Parameters:
WORD_SIZE, 8, data word width in bits
ADDR_SIZE, 8, byte-address width on addr_bus
ADDR_STEP_LOG2, 1, log2 of address stride per word (stride 2); entry index = addr_bus >> ADDR_STEP_LOG2
DEPTH, 2**(ADDR_SIZE-ADDR_STEP_LOG2), number of stored words (128 by default)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
addr_bus  in  ADDR_SIZE  byte address from CPU (registered at CPU side)
data_bus  inout  WORD_SIZE  shared data bus; driven by this block only on reads
wr_en  in  1  CPU write strobe
cpu_boot_done  in  1  CPU boot-done flag; CPU bus traffic is honoured only while high
ld_valid  in  1  preload write request
ld_addr  in  ADDR_SIZE  preload byte address
ld_data  in  WORD_SIZE  preload data
ld_ready  out  1  high when preload writes are accepted
mem_ready  out  1  high in SERVE state
wr_count  out  16  count of committed CPU writes, saturating at 16'hFFFF
misalign  out  1  sticky: a CPU or preload access used an address with nonzero low ADDR_STEP_LOG2 bits

Behaviour:
- States: INIT (0), LOAD (1), SERVE (2). Reset is synchronous; rst high at a clock edge forces:
  - state=INIT, clear index=0
  - ld_ready=0, mem_ready=0, wr_count=0, misalign=0
  - data_bus released (Z)
  - Reset mid-operation aborts any clear, preload or serve activity identically.
- INIT:
  - Writes 0 to entry[clear index] each cycle, then increments the index.
  - After entry DEPTH-1 is written: index wraps to 0, next state LOAD.
  - Occupies exactly DEPTH cycles (128 by default).
  - Ignores ld_valid, wr_en and addr_bus.
- LOAD:
  - ld_ready=1.
  - On an edge with ld_valid=1: entry[ld_addr>>ADDR_STEP_LOG2] <= ld_data. Low address bits are ignored; nonzero low bits set misalign.
  - CPU wr_en is ignored here. The CPU asserts wr_en during its boot sweep with the bus undriven, and those writes must not corrupt memory.
  - data_bus stays Z.
  - Leave for SERVE on the first edge where cpu_boot_done=1. A preload on that same edge is still committed; ld_ready drops the following cycle.
- SERVE:
  - mem_ready=1, ld_ready=0; ld_valid is ignored.
  - Read: while wr_en=0, data_bus is driven combinationally with entry[addr_bus>>ADDR_STEP_LOG2]. There is zero added latency, so the CPU samples valid data at the edge after addr_bus changes.
  - Write: while wr_en=1, data_bus is released (Z). On the edge, entry[addr_bus>>ADDR_STEP_LOG2] <= data_bus and wr_count increments unless already 16'hFFFF.
  - A write followed by a read of the same address in the next cycle returns the new value.
  - Nonzero low address bits on any SERVE read or write set misalign. The access proceeds on the truncated index.
  - If cpu_boot_done falls (CPU reset), return to LOAD on that edge. Memory contents are retained; wr_count and misalign are held.
- Bus contention rule: data_bus is never driven in INIT or LOAD, nor while wr_en=1. It is driven only when state=SERVE, wr_en=0 and cpu_boot_done=1.
- Address wrap: byte address 2**ADDR_SIZE-2 maps to entry DEPTH-1. No out-of-range index is possible.
- Outputs ld_ready and mem_ready are decoded from the registered state. wr_count and misalign are registered.

Test Plan:
- Reset, hold cpu_boot_done=0 -> mem_ready=0, ld_ready=0 for 128 cycles, ld_ready=1 on cycle 129. Reading every entry via the preload-free SERVE path later returns 8'h00.
- In LOAD, preload addr 0->8'h01, 2->8'h05, 4->8'h07 with wr_en=1 and data_bus=Z throughout -> entries hold exactly 01/05/07, no X written, wr_count=0.
- Raise cpu_boot_done, CPU reads addr 0/2/4 with wr_en=0 -> data_bus shows 8'h01, 8'h05, 8'h07 in the same cycle each address is presented. mem_ready=1.
- In SERVE, CPU drives wr_en=1, data_bus=8'h0C at addr 6; next cycle reads addr 6 with wr_en=0 -> block releases bus during write, returns 8'h0C after, wr_count=1.
- Read addr 3 in SERVE -> returns entry 1 (8'h05), misalign=1 and stays 1 after further aligned accesses until rst.
- Assert rst mid-SERVE after 3 writes -> next cycle wr_count=0, misalign=0, state INIT, data_bus Z. After 128 cycles all entries read 0. Separately, deassert cpu_boot_done in SERVE -> LOAD, contents preserved.
